// File: rtl/bus_pkg.sv
// Shared bus definitions: command encoding and default widths used by the CPU core,
// memory and the bus arbiter.
package bus_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 16;

  typedef enum logic [1:0] {
    NOP   = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10
  } bus_cmd_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_WAIT    = 2'b01,
    ARB_RECOVER = 2'b10
  } arb_state_t;

  // Only READ and WRITE reach memory; NOP and the unused 2'b11 complete locally.
  function automatic logic is_mem_cmd(input logic [1:0] cmd);
    return (cmd == READ) || (cmd == WRITE);
  endfunction

endpackage

// File: rtl/bus_rr_picker.sv
// Combinational round-robin priority encoder: returns the first pending index
// at or after ptr, wrapping from NREQ-1 back to 0.
module bus_rr_picker #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  pending,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int j;

  // Scan from the farthest candidate down so the nearest pending one wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (pending[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake memory bus among NREQ requesters.
// Optional WAIT-state timeout with forced completion when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int ADDR_W         = BUS_ADDR_W,
  parameter int DATA_W         = BUS_DATA_W,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IDX_W         = $clog2(NREQ)
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*2-1:0]      req_cmd,
  input  logic [NREQ-1:0]        req_run,
  input  logic [NREQ*DATA_W-1:0] req_wr_data,
  output logic [NREQ*DATA_W-1:0] req_rd_data,
  output logic [NREQ-1:0]        req_done,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [1:0]             mem_cmd,
  output logic                   mem_run,
  output logic [DATA_W-1:0]      mem_wr_data,
  input  logic [DATA_W-1:0]      mem_rd_data,
  input  logic                   mem_done,
  output logic [IDX_W-1:0]       grant_id,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [1:0]             fsm_state
);

  // Handshake: a side starts a transaction by toggling run (holding addr/cmd/data
  // stable); the other side completes it by making done equal run again.
  // A port is pending whenever run != done.

  arb_state_t              state, state_n;
  logic [IDX_W-1:0]        rr_ptr, rr_ptr_n;
  logic [IDX_W-1:0]        grant_n;
  logic [NREQ-1:0]         req_done_n;
  logic [NREQ*DATA_W-1:0]  req_rd_data_n;
  logic [ADDR_W-1:0]       mem_addr_n;
  logic [1:0]              mem_cmd_n;
  logic                    mem_run_n;
  logic [DATA_W-1:0]       mem_wr_data_n;

  logic [NREQ-1:0]         pending;
  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_idx;
  logic [1:0]              pick_cmd;
  logic                    mem_complete;

  assign pending      = req_run ^ req_done;
  assign pick_cmd     = req_cmd[pick_idx*2 +: 2];
  assign mem_complete = (mem_done == mem_run);
  assign busy         = (state != ARB_IDLE);
  assign fsm_state    = state;

  bus_rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .pending (pending),
    .ptr     (rr_ptr),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
  logic             timeout_err_n;
`endif

  always_comb begin
    state_n       = state;
    rr_ptr_n      = rr_ptr;
    grant_n       = grant_id;
    req_done_n    = req_done;
    req_rd_data_n = req_rd_data;
    mem_addr_n    = mem_addr;
    mem_cmd_n     = mem_cmd;
    mem_run_n     = mem_run;
    mem_wr_data_n = mem_wr_data;
`ifdef BUS_ARB_TIMEOUT_EN
    wait_cnt_n    = wait_cnt;
    timeout_err_n = timeout_err;
`endif
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_n  = pick_idx;
          rr_ptr_n = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          if (is_mem_cmd(pick_cmd)) begin
            mem_addr_n    = req_addr[pick_idx*ADDR_W +: ADDR_W];
            mem_cmd_n     = pick_cmd;
            mem_wr_data_n = req_wr_data[pick_idx*DATA_W +: DATA_W];
            mem_run_n     = ~mem_run;
            state_n       = ARB_WAIT;
`ifdef BUS_ARB_TIMEOUT_EN
            wait_cnt_n    = '0;
`endif
          end else begin
            req_done_n[pick_idx] = ~req_done[pick_idx];
          end
        end
      end
      ARB_WAIT: begin
        if (mem_complete) begin
          if (mem_cmd == READ) req_rd_data_n[grant_id*DATA_W +: DATA_W] = mem_rd_data;
          req_done_n[grant_id] = ~req_done[grant_id];
          state_n              = ARB_IDLE;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Give up on the requester but keep the memory port reserved until it answers.
          if (mem_cmd == READ) req_rd_data_n[grant_id*DATA_W +: DATA_W] = '1;
          req_done_n[grant_id] = ~req_done[grant_id];
          timeout_err_n        = 1'b1;
          state_n              = ARB_RECOVER;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
`endif
      end
      ARB_RECOVER: begin
        if (mem_complete) state_n = ARB_IDLE;
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      req_done    <= '0;
      req_rd_data <= '0;
      mem_addr    <= '0;
      mem_cmd     <= NOP;
      mem_run     <= 1'b0;
      mem_wr_data <= '0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      grant_id    <= grant_n;
      req_done    <= req_done_n;
      req_rd_data <= req_rd_data_n;
      mem_addr    <= mem_addr_n;
      mem_cmd     <= mem_cmd_n;
      mem_run     <= mem_run_n;
      mem_wr_data <= mem_wr_data_n;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt    <= wait_cnt_n;
      timeout_err <= timeout_err_n;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: 1-cycle memory stub, read-data scoreboard,
// latency, round-robin, NOP, reset-in-WAIT and timeout (BUS_ARB_TIMEOUT_EN) cases.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 16;
  localparam int DW   = 16;

  // clock / reset
  logic sysclk = 1'b0;
  logic reset;
  always #5 sysclk = ~sysclk;

  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*2-1:0]  req_cmd;
  logic [NREQ-1:0]    req_run;
  logic [NREQ*DW-1:0] req_wr_data;
  logic [NREQ*DW-1:0] req_rd_data;
  logic [NREQ-1:0]    req_done;
  logic [AW-1:0]      mem_addr;
  logic [1:0]         mem_cmd;
  logic               mem_run;
  logic [DW-1:0]      mem_wr_data;
  logic [DW-1:0]      mem_rd_data;
  logic               mem_done;
  logic               grant_id;
  logic               busy;
  logic               timeout_err;
  logic [1:0]         fsm_state;

  bus_arbiter #(
    .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)
  ) dut (
    .sysclk(sysclk), .reset(reset),
    .req_addr(req_addr), .req_cmd(req_cmd), .req_run(req_run), .req_wr_data(req_wr_data),
    .req_rd_data(req_rd_data), .req_done(req_done),
    .mem_addr(mem_addr), .mem_cmd(mem_cmd), .mem_run(mem_run), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_done(mem_done),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err), .fsm_state(fsm_state)
  );

  // 1-cycle memory stub; stub_en=0 makes it never answer
  logic [DW-1:0] stub_mem [16];
  logic          stub_en;

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 1) return 16'h1800;
    if (a == 3) return 16'h1b00;
    return 16'(a) * 16'h1111;
  endfunction

  always @(posedge sysclk) begin
    if (reset) begin
      mem_done    <= 1'b0;
      mem_rd_data <= '0;
      for (int a = 0; a < 16; a++) stub_mem[a] <= init_val(a);
    end else if (stub_en && (mem_run != mem_done)) begin
      if (mem_cmd == WRITE) stub_mem[mem_addr[3:0]] <= mem_wr_data;
      mem_rd_data <= stub_mem[mem_addr[3:0]];
      mem_done    <= mem_run;
    end
  end

  // scoreboard
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [16];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic model_init();
    for (int a = 0; a < 16; a++) model_mem[a] = init_val(a);
  endtask

  function automatic logic [DW-1:0] rd(input int i);
    return req_rd_data[i*DW +: DW];
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic issue(input int i, input logic [1:0] cmd, input logic [15:0] addr,
                       input logic [15:0] wd);
    req_cmd[i*2 +: 2]      = cmd;
    req_addr[i*AW +: AW]   = addr;
    req_wr_data[i*DW +: DW] = wd;
    if (cmd == READ) exp_q.push_back(model_mem[addr[3:0]]);
    if (cmd == WRITE) model_mem[addr[3:0]] = wd;
    req_run[i] = ~req_run[i];
  endtask

  task automatic wait_done(input int i, input string tag);
    int n = 0;
    while (req_done[i] != req_run[i] && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_done_in_time"}, 32'(req_done[i] == req_run[i]), 1);
  endtask

  task automatic wait_read(input int i, input string tag);
    wait_done(i, tag);
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 0, 1);
    else check({tag, "_rd"}, rd(i), exp_q.pop_front());
  endtask

  int  grants[$];
  int  issued;
  logic prev_run;

  initial begin
    reset = 1'b1; stub_en = 1'b1;
    req_addr = '0; req_cmd = '0; req_run = '0; req_wr_data = '0;
    model_init();
    tick(); tick();
    check("rst_done", req_done, 0);
    check("rst_rd", req_rd_data, 0);
    check("rst_mem_run", mem_run, 0);
    check("rst_mem_cmd", mem_cmd, NOP);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_tmo", timeout_err, 0);
    reset = 1'b0;

    // 1: single read, latency
    issue(0, READ, 16'h0003, 16'h0);
    tick();
    check("t1_mem_run", mem_run, 1);
    check("t1_mem_addr", mem_addr, 16'h0003);
    check("t1_busy", busy, 1);
    check("t1_done_e0", req_done[0], 0);
    tick();
    check("t1_done_e1", req_done[0], 0);
    tick();
    check("t1_done_e2", req_done[0], 1);
    check("t1_idle", busy, 0);
    check("t1_rd", rd(0), exp_q.pop_front());

    // 4: NOP on req1 completes on the grant edge and moves the pointer to 0
    issue(1, NOP, 16'h0, 16'h0);
    tick();
    check("t4_done", req_done[1], 1);
    check("t4_grant", grant_id, 1);
    check("t4_mem_run", mem_run, 1);
    check("t4_busy", busy, 0);

    // 2: write then read, same cycle
    issue(0, WRITE, 16'h000f, 16'h1234);
    issue(1, READ, 16'h000f, 16'h0);
    tick();
    check("t2_grant0", grant_id, 0);
    check("t2_cmd0", mem_cmd, WRITE);
    wait_done(0, "t2_w");
    tick();
    check("t2_grant1", grant_id, 1);
    check("t2_cmd1", mem_cmd, READ);
    wait_read(1, "t2_r");

    // 3: back-to-back alternation
    issue(0, WRITE, 16'h0008, 16'h0001);
    issue(1, WRITE, 16'h0009, 16'h0002);
    issued = 2;
    prev_run = mem_run;
    for (int c = 0; c < 100 && grants.size() < 8; c++) begin
      tick();
      if (mem_run != prev_run) begin
        grants.push_back(int'(grant_id));
        prev_run = mem_run;
      end
      for (int i = 0; i < 2; i++)
        if (req_done[i] == req_run[i] && issued < 8) begin
          issue(i, WRITE, 16'(8 + i), 16'(c));
          issued++;
        end
    end
    check("t3_count", grants.size(), 8);
    foreach (grants[k]) check($sformatf("t3_grant%0d", k), grants[k], k % 2);
    wait_done(0, "t3_end0");
    wait_done(1, "t3_end1");

    // 5: reset while WAIT
    issue(0, READ, 16'h0002, 16'h0);
    tick();
    check("t5_busy_pre", busy, 1);
    reset = 1'b1;
    req_run = '0;
    tick();
    check("t5_busy", busy, 0);
    check("t5_mem_run", mem_run, 0);
    check("t5_done", req_done, 0);
    check("t5_rd", req_rd_data, 0);
    check("t5_cmd", mem_cmd, NOP);
    check("t5_addr", mem_addr, 0);
    check("t5_grant", grant_id, 0);
    reset = 1'b0;
    exp_q.delete();
    model_init();
    issue(0, READ, 16'h0001, 16'h0);
    wait_read(0, "t5_after");

    // 6: memory never answers
    stub_en = 1'b0;
    issue(1, READ, 16'h0004, 16'h0);
`ifdef BUS_ARB_TIMEOUT_EN
    exp_q.delete();
    tick();
    check("t6_busy", busy, 1);
    repeat (3) tick();
    check("t6_pending_e3", 32'(req_done[1] != req_run[1]), 1);
    tick();
    check("t6_forced_done", 32'(req_done[1] == req_run[1]), 1);
    check("t6_rd_ones", rd(1), 16'hffff);
    check("t6_tmo", timeout_err, 1);
    check("t6_recover", busy, 1);
    issue(0, READ, 16'h0003, 16'h0);
    prev_run = mem_run;
    repeat (5) tick();
    check("t6_no_grant", mem_run, prev_run);
    check("t6_req0_wait", 32'(req_done[0] != req_run[0]), 1);
    stub_en = 1'b1;
    wait_read(0, "t6_after");
    check("t6_tmo_sticky", timeout_err, 1);
`else
    repeat (20) tick();
    check("t6_no_done", 32'(req_done[1] != req_run[1]), 1);
    check("t6_busy", busy, 1);
    check("t6_tmo_off", timeout_err, 0);
    stub_en = 1'b1;
    wait_read(1, "t6_late");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
